// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A - B - BIN using one full-subtractor cell,
// LSB first, WIDTH cycles per operation, registered result + done pulse.
// Ports: clk, rst_n (async, active-low), start, a, b, bin in;
//        busy, done, diff, bout out; zero, ovf out with SERSUB_FLAGS_EN.
// Optional feature macro: SERSUB_FLAGS_EN (zero / signed-overflow flags).
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] dsr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] nxt_d;
    logic             load;

`ifdef SERSUB_FLAGS_EN
    // Operand sign bits are shifted out of sa/sb, so keep them aside.
    logic             am;
    logic             bm;
`endif

    always_comb begin
        cell_d  = sa[0] ^ sb[0] ^ brw;
        cell_bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
        nxt_d   = {cell_d, dsr[WIDTH-1:1]};
        load    = start && (state != S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            dsr   <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
`ifdef SERSUB_FLAGS_EN
            zero  <= 1'b0;
            ovf   <= 1'b0;
            am    <= 1'b0;
            bm    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                sa  <= a;
                sb  <= b;
                brw <= bin;
                cnt <= '0;
`ifdef SERSUB_FLAGS_EN
                am  <= a[WIDTH-1];
                bm  <= b[WIDTH-1];
`endif
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    dsr <= nxt_d;
                    brw <= cell_bo;
                    if (cnt == LAST) begin
                        diff  <= nxt_d;
                        bout  <= cell_bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
`ifdef SERSUB_FLAGS_EN
                        zero  <= (nxt_d == '0);
                        ovf   <= (am != bm) && (cell_d != am);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
